// File: rtl/counter_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// counter_seq_ctrl_if
// Bundles the system-control and ripple-counter signals of the counter
// sequencer so that they can be passed around as one port.
//
//   START     request to begin a run (sampled by the sequencer in IDLE)
//   STOP      abort request
//   MODE      0 one-shot, 1 periodic auto-reload
//   LOAD_VAL  preset value for the counter
//   TERM_VAL  terminal value that ends a run
//   CNT_Q     counter Q output
//   CNT_C     count clock to the counter
//   CNT_CLR   counter preset strobe
//   CNT_DCLR  preset data to the counter
//   BUSY      sequencer is not idle
//   DONE      one-cycle pulse, run reached TERM_VAL
//   WRAP      one-cycle pulse, expected value wrapped all-ones -> 0
//   ERR       sticky mismatch flag
//
// slave  : the sequencer side
// master : system control plus counter side
// ----------------------------------------------------------------------------
interface counter_seq_ctrl_if #(
    parameter int DATA_WIDTH = 4
);
    logic                  START;
    logic                  STOP;
    logic                  MODE;
    logic [DATA_WIDTH-1:0] LOAD_VAL;
    logic [DATA_WIDTH-1:0] TERM_VAL;
    logic [DATA_WIDTH-1:0] CNT_Q;
    logic                  CNT_C;
    logic                  CNT_CLR;
    logic [DATA_WIDTH-1:0] CNT_DCLR;
    logic                  BUSY;
    logic                  DONE;
    logic                  WRAP;
    logic                  ERR;

    modport slave (
        input  START, STOP, MODE, LOAD_VAL, TERM_VAL, CNT_Q,
        output CNT_C, CNT_CLR, CNT_DCLR, BUSY, DONE, WRAP, ERR
    );

    modport master (
        output START, STOP, MODE, LOAD_VAL, TERM_VAL, CNT_Q,
        input  CNT_C, CNT_CLR, CNT_DCLR, BUSY, DONE, WRAP, ERR
    );
endinterface

// File: rtl/counter_seq_ctrl.sv
// ----------------------------------------------------------------------------
// counter_seq_ctrl
// Sequencer for a ripple counter with a DCLR/C/CLR interface. It presets the
// counter, issues count pulses one at a time, lets the ripple chain settle
// after each event and compares Q with an internally tracked expected value.
// A run ends with DONE when Q reaches the terminal value; in periodic mode the
// run then reloads and repeats until STOP or reset.
//
// Ports
//   C       clock, all logic on the rising edge
//   notRST  synchronous active-low reset
//   bus     counter_seq_ctrl_if.slave (control inputs, counter Q, all outputs)
//
// All outputs are registered. Each output register captures the decode of the
// state the FSM is leaving at that edge, so the visible waveform trails the
// state register by one cycle; STOP clears the decode so outputs drop on the
// same edge that returns the FSM to IDLE.
// ----------------------------------------------------------------------------
module counter_seq_ctrl #(
    parameter int DATA_WIDTH = 4,
    parameter int CLR_CYC    = 1,
    parameter int SETTLE_CYC = 2
) (
    input  logic                C,
    input  logic                notRST,
    counter_seq_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        CHECK,
        PULSE,
        LOW,
        FIN
    } state_t;

    // One shared dwell counter serves both LOAD and SETTLE.
    localparam int MAX_CYC = (CLR_CYC > SETTLE_CYC) ? CLR_CYC : SETTLE_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] CLR_LAST    = CW'(CLR_CYC - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);

    state_t                state_q;
    state_t                state_d;
    logic [CW-1:0]         cyc_q;

    logic [DATA_WIDTH-1:0] load_q;
    logic [DATA_WIDTH-1:0] term_q;
    logic                  mode_q;
    logic [DATA_WIDTH-1:0] exp_q;
    logic                  err_q;

    logic                  cnt_c_q,  cnt_c_d;
    logic                  cnt_clr_q, cnt_clr_d;
    logic                  busy_q,   busy_d;
    logic                  done_q,   done_d;
    logic                  wrap_q,   wrap_d;

    logic                  accept;
    logic                  mismatch;

    assign accept   = (state_q == IDLE) && bus.START && !bus.STOP;
    assign mismatch = (bus.CNT_Q != exp_q);

    // ------------------------------------------------------------------
    // State register and dwell counter
    // ------------------------------------------------------------------
    // NOTE: every clocked process uses non-blocking assignments so that all
    // registers sample the pre-edge values of each other.
    always_ff @(posedge C) begin
        if (!notRST) begin
            state_q <= IDLE;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            // Restart the dwell count on every state change.
            cyc_q   <= (state_d != state_q) ? '0 : cyc_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        if (bus.STOP) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (bus.START) state_d = LOAD;
                LOAD:    if (cyc_q == CLR_LAST) state_d = SETTLE;
                SETTLE:  if (cyc_q == SETTLE_LAST) state_d = CHECK;
                CHECK: begin
                    if (mismatch)                   state_d = IDLE;
                    else if (bus.CNT_Q == term_q)   state_d = FIN;
                    else                            state_d = PULSE;
                end
                PULSE:   state_d = LOW;
                LOW:     state_d = SETTLE;
                FIN:     state_d = mode_q ? LOAD : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode (captured by the output register below)
    // ------------------------------------------------------------------
    always_comb begin
        busy_d    = (state_q != IDLE);
        cnt_clr_d = (state_q == LOAD);
        cnt_c_d   = (state_q == PULSE);
        done_d    = (state_q == FIN);
        wrap_d    = (state_q == PULSE) && (&exp_q);
        if (bus.STOP) begin
            busy_d    = 1'b0;
            cnt_clr_d = 1'b0;
            cnt_c_d   = 1'b0;
            done_d    = 1'b0;
            wrap_d    = 1'b0;
        end
    end

    always_ff @(posedge C) begin
        if (!notRST) begin
            cnt_c_q   <= 1'b0;
            cnt_clr_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            cnt_c_q   <= cnt_c_d;
            cnt_clr_q <= cnt_clr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wrap_q    <= wrap_d;
        end
    end

    // ------------------------------------------------------------------
    // Run parameters, expected value and error flag
    // ------------------------------------------------------------------
    always_ff @(posedge C) begin
        if (!notRST) begin
            load_q <= '0;
            term_q <= '0;
            mode_q <= 1'b0;
            exp_q  <= '0;
            err_q  <= 1'b0;
        end else if (accept) begin
            load_q <= bus.LOAD_VAL;
            term_q <= bus.TERM_VAL;
            mode_q <= bus.MODE;
            exp_q  <= bus.LOAD_VAL;
            err_q  <= 1'b0;
        end else if (!bus.STOP) begin
            unique case (state_q)
                // Periodic reload re-arms the expected value from the
                // latched preset.
                LOAD:    exp_q <= load_q;
                CHECK:   if (mismatch) err_q <= 1'b1;
                // Wraps naturally modulo 2^DATA_WIDTH.
                PULSE:   exp_q <= exp_q + 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.CNT_C    = cnt_c_q;
    assign bus.CNT_CLR  = cnt_clr_q;
    assign bus.CNT_DCLR = load_q;
    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;
    assign bus.WRAP     = wrap_q;
    assign bus.ERR      = err_q;

endmodule
